replica_exchange_seq: RTL and testbench

//  Sequencer for the replica-exchange phase of the annealer. It drives the shared exp unit
//  (exp_init/exp_run/exp_fin/exp_recip) and the opt_run/opt_com command broadcast. It also

---
 rtl/replica_exchange_seq_if.sv | 37 +++
 rtl/replica_exchange_seq.sv | 152 +++++++++++++++
 tb/tb_replica_exchange_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/replica_exchange_seq_if.sv
// Bundle between the replica-exchange sequencer and its surroundings: run control in,
// exp-unit and replica_d command strobes out.
interface replica_exchange_seq_if #(
    parameter int ITER_W = 16
);
    // Handshake: start is a 1-cycle request with no ready. It is taken only while the
    // sequencer is idle (busy low) and abort is low; a start at any other time is dropped.
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] iter_num;
    logic [16:0]       recip_cfg;
    logic              ordering_req;

    logic              busy;
    logic              done;
    logic              opt_run;
    logic [1:0]        opt_com;
    logic              exchange_phase;
    logic              exchange_shift_d;
    logic              ordering_ack;
    logic              exp_init;
    logic              exp_run;
    logic              exp_fin;
    logic [16:0]       exp_recip;

    modport master (
        output start, abort, iter_num, recip_cfg, ordering_req,
        input  busy, done, opt_run, opt_com, exchange_phase, exchange_shift_d,
               ordering_ack, exp_init, exp_run, exp_fin, exp_recip
    );

    modport slave (
        input  start, abort, iter_num, recip_cfg, ordering_req,
        output busy, done, opt_run, opt_com, exchange_phase, exchange_shift_d,
               ordering_ack, exp_init, exp_run, exp_fin, exp_recip
    );
endinterface

// File: rtl/replica_exchange_seq.sv
// Replica-exchange phase sequencer: steps the exp unit, issues OR1/TWO commands to the
// replica_d chain and optionally runs an ordering shift burst after each iteration.
module replica_exchange_seq #(
    parameter int REPLICA_NUM = 32,
    parameter int EXP_CYCLES  = 16,
    parameter int ITER_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    replica_exchange_seq_if.slave        bus,
    output logic [3:0]                   dbg_state_o
);

    localparam logic [1:0] COM_NOP = 2'd0;
    localparam logic [1:0] COM_OR1 = 2'd1;
    localparam logic [1:0] COM_TWO = 2'd2;

    // One down-counter serves both the exp run window and the shift burst.
    localparam int CNT_MAX = (REPLICA_NUM > EXP_CYCLES) ? REPLICA_NUM : EXP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(EXP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(REPLICA_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_RUN     = 4'd2,
        S_FIN     = 4'd3,
        S_TEST    = 4'd4,
        S_RESOLVE = 4'd5,
        S_APPLY   = 4'd6,
        S_SHIFT   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0] iter_num_q, iter_num_d;
    logic [16:0]       recip_q, recip_d;
    logic              phase_q, phase_d;
    logic              last_iter;

    logic              busy_q, done_q, opt_run_q, shift_q, ack_q;
    logic              exp_init_q, exp_run_q, exp_fin_q;
    logic [1:0]        opt_com_q;

    assign last_iter = (iter_cnt_q == (iter_num_q - ITER_W'(1)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        iter_cnt_d = iter_cnt_q;
        iter_num_d = iter_num_q;
        recip_d    = recip_q;
        phase_d    = phase_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    iter_num_d = bus.iter_num;
                    recip_d    = bus.recip_cfg;
                    iter_cnt_d = '0;
                    phase_d    = 1'b0;
                    state_d    = (bus.iter_num == '0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_RUN;
                cnt_d   = RUN_LOAD;
            end
            S_RUN: begin
                if (cnt_q == '0) state_d = S_FIN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FIN:     state_d = S_TEST;
            S_TEST:    state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_APPLY;
            S_APPLY, S_SHIFT: begin
                if (state_q == S_APPLY && bus.ordering_req) begin
                    state_d = S_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else if (state_q == S_SHIFT && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (last_iter) begin
                    state_d = S_DONE;
                end else begin
                    iter_cnt_d = iter_cnt_q + ITER_W'(1);
                    phase_d    = ~phase_q;
                    state_d    = S_INIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides every transition out of a non-idle state
        if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Strobes are decoded from the next state so they are valid in the entry cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            iter_cnt_q <= '0;
            iter_num_q <= '0;
            recip_q    <= '0;
            phase_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            opt_run_q  <= 1'b0;
            opt_com_q  <= COM_NOP;
            shift_q    <= 1'b0;
            ack_q      <= 1'b0;
            exp_init_q <= 1'b0;
            exp_run_q  <= 1'b0;
            exp_fin_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iter_cnt_q <= iter_cnt_d;
            iter_num_q <= iter_num_d;
            recip_q    <= recip_d;
            phase_q    <= phase_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            opt_run_q  <= (state_d == S_TEST) || (state_d == S_RESOLVE);
            opt_com_q  <= (state_d == S_TEST)    ? COM_OR1 :
                          (state_d == S_RESOLVE) ? COM_TWO : COM_NOP;
            shift_q    <= (state_d == S_SHIFT);
            ack_q      <= (state_d == S_SHIFT) && (cnt_d == '0);
            exp_init_q <= (state_d == S_INIT);
            exp_run_q  <= (state_d == S_RUN);
            exp_fin_q  <= (state_d == S_FIN);
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.opt_run          = opt_run_q;
    assign bus.opt_com          = opt_com_q;
    assign bus.exchange_phase   = phase_q;
    assign bus.exchange_shift_d = shift_q;
    assign bus.ordering_ack     = ack_q;
    assign bus.exp_init         = exp_init_q;
    assign bus.exp_run          = exp_run_q;
    assign bus.exp_fin          = exp_fin_q;
    assign bus.exp_recip        = recip_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_replica_exchange_seq.sv
// Directed bench for replica_exchange_seq with exp_cycles=4 and replica_num=32,
// so one iteration without a shift spans 9 cycles.
module tb_replica_exchange_seq;

    localparam int REPLICA_NUM = 32;
    localparam int EXP_CYCLES  = 4;
    localparam int ITER_W      = 16;
    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] OR1 = 2'd1;
    localparam logic [1:0] TWO = 2'd2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dbg_state;
    int         n_pass  = 0;
    int         n_total = 0;

    replica_exchange_seq_if #(.ITER_W(ITER_W)) bus ();

    replica_exchange_seq #(
        .REPLICA_NUM (REPLICA_NUM),
        .EXP_CYCLES  (EXP_CYCLES),
        .ITER_W      (ITER_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, exp_init, exp_run, exp_fin, opt_run, opt_com[1:0], shift, ack}
    function automatic logic [9:0] obs();
        return {bus.busy, bus.done, bus.exp_init, bus.exp_run, bus.exp_fin,
                bus.opt_run, bus.opt_com, bus.exchange_shift_d, bus.ordering_ack};
    endfunction

    task automatic drain();
        for (int i = 0; i < 80 && bus.busy; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs() !== 10'b0 || bus.exp_recip !== 17'h0 || bus.exchange_phase !== 1'b0 || dbg_state !== 4'd0)
            $display("FAIL reset_values got=%b recip=%h st=%0d exp=0", obs(), bus.exp_recip, dbg_state);
        else n_pass++;
        reset = 1'b1;
        tick();
        bus.iter_num = 16'd1; bus.recip_cfg = 17'h01234; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        n_total++;
        if (bus.exp_run !== 1'b1) $display("FAIL reset_pre_run got=%b exp=1", bus.exp_run);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (obs() !== 10'b0 || bus.exp_recip !== 17'h0 || dbg_state !== 4'd0)
            $display("FAIL reset_midrun got=%b recip=%h st=%0d exp=0", obs(), bus.exp_recip, dbg_state);
        else n_pass++;
        #2 reset = 1'b1;
        tick(); tick();
        n_total++;
        if (obs() !== 10'b0 || dbg_state !== 4'd0)
            $display("FAIL reset_release_idle got=%b st=%0d exp=0", obs(), dbg_state);
        else n_pass++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (obs() !== 10'b10_1000_0000) $display("FAIL reset_restart got=%b exp=%b", obs(), 10'b10_1000_0000);
        else n_pass++;
        drain();
    endtask

    task automatic test_single_iter();
        logic [9:0] exp_q[$];
        logic [9:0] e;
        for (int k = 1; k <= 12; k++) begin
            e = '0;
            e[9]   = (k <= 10);
            e[8]   = (k == 10);
            e[7]   = (k == 1);
            e[6]   = (k >= 2 && k <= 5);
            e[5]   = (k == 6);
            e[4]   = (k == 7 || k == 8);
            e[3:2] = (k == 7) ? OR1 : (k == 8) ? TWO : NOP;
            exp_q.push_back(e);
        end
        bus.iter_num = 16'd1; bus.recip_cfg = 17'h1abcd; bus.start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            bus.start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (obs() !== e) $display("FAIL single_c%0d got=%b exp=%b", k, obs(), e);
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if (bus.exp_recip !== 17'h1abcd || bus.exchange_phase !== 1'b0)
                    $display("FAIL single_recip got=%h ph=%b exp=1abcd ph=0", bus.exp_recip, bus.exchange_phase);
                else n_pass++;
            end
        end
    endtask

    task automatic test_multi_iter();
        int n_or1 = 0, n_two = 0, done_cyc = -1;
        int init_cyc[$];
        logic ph[$];
        bus.iter_num = 16'd3; bus.start = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            bus.start = (k == 5);
            if (k == 2) bus.iter_num = 16'd7;
            if (bus.opt_run && bus.opt_com == OR1) n_or1++;
            if (bus.opt_run && bus.opt_com == TWO) n_two++;
            if (bus.exp_init) begin init_cyc.push_back(k); ph.push_back(bus.exchange_phase); end
            if (bus.done && done_cyc < 0) done_cyc = k;
        end
        bus.start = 1'b0;
        n_total++;
        if (n_or1 != 3 || n_two != 3) $display("FAIL multi_cmds got=%0d/%0d exp=3/3", n_or1, n_two);
        else n_pass++;
        n_total++;
        if (init_cyc.size() != 3) $display("FAIL multi_init_count got=%0d exp=3", init_cyc.size());
        else begin
            n_pass++;
            n_total++;
            if (init_cyc[0] != 1 || init_cyc[1] != 10 || init_cyc[2] != 19)
                $display("FAIL multi_init_cyc got=%0d,%0d,%0d exp=1,10,19", init_cyc[0], init_cyc[1], init_cyc[2]);
            else n_pass++;
            n_total++;
            if (ph[0] !== 1'b0 || ph[1] !== 1'b1 || ph[2] !== 1'b0)
                $display("FAIL multi_phase got=%b%b%b exp=010", ph[0], ph[1], ph[2]);
            else n_pass++;
        end
        n_total++;
        if (done_cyc != 28 || bus.busy !== 1'b0) $display("FAIL multi_done got=%0d busy=%b exp=28 busy=0", done_cyc, bus.busy);
        else n_pass++;
    endtask

    task automatic test_shift();
        int sh_first = -1, sh_last = -1, sh_cnt = 0, ack_cyc = -1, ack_cnt = 0, done_cyc = -1;
        int init_cyc[$];
        logic ph3 = 1'b1;
        logic [3:0] st18 = 4'hf;
        bus.iter_num = 16'd3; bus.start = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            bus.start = 1'b0;
            bus.ordering_req = (k == 18);
            if (k == 18) st18 = dbg_state;
            if (bus.exchange_shift_d) begin
                if (sh_first < 0) sh_first = k;
                sh_last = k; sh_cnt++;
            end
            if (bus.ordering_ack) begin ack_cyc = k; ack_cnt++; end
            if (bus.exp_init) begin
                init_cyc.push_back(k);
                if (init_cyc.size() == 3) ph3 = bus.exchange_phase;
            end
            if (bus.done && done_cyc < 0) done_cyc = k;
        end
        bus.ordering_req = 1'b0;
        n_total++;
        if (st18 !== 4'd6) $display("FAIL shift_apply_state got=%0d exp=6", st18);
        else n_pass++;
        n_total++;
        if (sh_cnt != 32 || sh_first != 19 || sh_last != 50)
            $display("FAIL shift_window got=%0d@%0d..%0d exp=32@19..50", sh_cnt, sh_first, sh_last);
        else n_pass++;
        n_total++;
        if (ack_cnt != 1 || ack_cyc != 50) $display("FAIL shift_ack got=%0dx@%0d exp=1x@50", ack_cnt, ack_cyc);
        else n_pass++;
        n_total++;
        if (init_cyc.size() != 3 || init_cyc[2] != 51 || ph3 !== 1'b0)
            $display("FAIL shift_third_init got=n%0d ph=%b exp=n3@51 ph=0", init_cyc.size(), ph3);
        else n_pass++;
        n_total++;
        if (done_cyc != 60) $display("FAIL shift_done got=%0d exp=60", done_cyc);
        else n_pass++;
    endtask

    task automatic test_zero_iter();
        bus.iter_num = 16'd0; bus.start = 1'b1;
        tick();
        n_total++;
        if (obs() !== 10'b11_0000_0000) $display("FAIL zero_done got=%b exp=%b", obs(), 10'b11_0000_0000);
        else n_pass++;
        bus.iter_num = 16'd1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (obs() !== 10'b0 || dbg_state !== 4'd0) $display("FAIL zero_start_busy got=%b st=%0d exp=0", obs(), dbg_state);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (obs() !== 10'b0) $display("FAIL zero_quiet got=%b exp=0", obs());
        else n_pass++;
    endtask

    task automatic test_abort();
        int n_done = 0, n_busy = 0;
        bus.iter_num = 16'd2; bus.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.start = 1'b0;
        end
        n_total++;
        if (bus.opt_run !== 1'b1 || bus.opt_com !== TWO) $display("FAIL abort_resolve got=%b/%0d exp=1/2", bus.opt_run, bus.opt_com);
        else n_pass++;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_total++;
        if (obs() !== 10'b0 || dbg_state !== 4'd0) $display("FAIL abort_next got=%b st=%0d exp=0", obs(), dbg_state);
        else n_pass++;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
        n_total++;
        if (n_done != 0 || n_busy != 0) $display("FAIL abort_quiet got=done%0d busy%0d exp=0", n_done, n_busy);
        else n_pass++;
        bus.iter_num = 16'd1; bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        n_total++;
        if (obs() !== 10'b0 || dbg_state !== 4'd0) $display("FAIL abort_start_idle got=%b st=%0d exp=0", obs(), dbg_state);
        else n_pass++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (obs() !== 10'b10_1000_0000) $display("FAIL abort_restart got=%b exp=%b", obs(), 10'b10_1000_0000);
        else n_pass++;
        drain();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL abort_drain got=%b exp=0", bus.busy);
        else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.ordering_req = 1'b0;
        bus.iter_num = '0; bus.recip_cfg = '0;
        test_reset();
        test_single_iter();
        test_multi_iter();
        test_shift();
        test_zero_iter();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
